kb_key_tracker: RTL and testbench
=================================

# kb_key_tracker

Keyboard scan-code sequencer between the single `ps2_rx` receiver and the game logic. Consumes the received byte stream once, decodes make, break (`F0`) and extended (`E0`) prefixes with a prefix state machine, and keeps held and press-event state for six game keys. It also arbitrates the four direction keys into one direction command, with the most recently pressed key winning. It replaces the per-key controller instances with one shared decoder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_000_000. Number of idle clk cycles after which a pending prefix is abandoned (20 ms at 100 MHz). The counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk`  in  1  System clock. This is the only clock.
- `reset`  in  1  Asynchronous, active-high reset.
- `scan_done_tick`  in  1  One-cycle strobe from `ps2_rx`: `scan_code` is valid.
- `scan_code`  in  8  Received byte.
- `key_held`  out  6  Level per key: 1 while the key is down.
- `key_press`  out  6  One-cycle pulse on the first make of a key.
- `dir`  out  2  Arbitrated direction: 0 left, 1 right, 2 up, 3 down.
- `dir_valid`  out  1  1 while any direction key is held.

Key index mapping:
- 0 left = `1C`
- 1 right = `23`
- 2 up = `1D`
- 3 down = `1B`
- 4 game_reset = `2D`
- 5 enter = `5A`

## Operation
Prefix state machine, one transition per `scan_done_tick`:
- IDLE:
  - `F0` → BREAK
  - `E0` → EXT
  - otherwise: make(code), stay in IDLE.
- BREAK:
  - `E0` → EXT_BREAK
  - `F0` → BREAK (no change)
  - otherwise: release(code) → IDLE
- EXT:
  - `F0` → EXT_BREAK
  - `E0` → EXT
  - otherwise: ext_make(code) → IDLE
- EXT_BREAK:
  - `E0`/`F0` → EXT_BREAK
  - otherwise: ext_release(code) → IDLE

Key state updates:
- `00` or `FF` (keyboard overrun) in any state: clear all `key_held`, clear the last-pressed register, → IDLE. No `key_press` pulse.
- make of a mapped key that is not held: set `key_held[i]` and pulse `key_press[i]`. If i is 0–3, also record i as last-pressed.
- make of a key already held (typematic repeat): no pulse. `key_held` and last-pressed are unchanged.
- release of a mapped key: clear `key_held[i]`. Releasing a key that is not held has no effect.
- Unmapped codes: the state transitions occur as above; no key effect.
- Extended codes are handled only per Configuration. Otherwise ext_make and ext_release have no key effect.

Arbitration:
- `dir_valid` = OR of `key_held[3:0]`.
- If the last-pressed key is still held, `dir` = last-pressed.
- Otherwise `dir` = the highest-priority held key, in the order up > down > left > right.
- When `dir_valid` = 0, `dir` = 0.

Timeout:
- A counter reloads on every tick.
- In any non-IDLE state, if `TIMEOUT_CYCLES` elapse with no tick, the state returns to IDLE. No key effect.

## Timing
- Reset values: `key_held` = 0, `key_press` = 0, `dir` = 0, `dir_valid` = 0, state = IDLE, last-pressed invalid, counter = 0.
- All outputs are registered. `key_held`, `key_press`, `dir` and `dir_valid` update on the clock edge after the `scan_done_tick` cycle, so latency is 1 cycle.
- `key_press` is high for exactly 1 cycle.
- `dir` and `dir_valid` change in the same cycle as the `key_held` change that causes them.
- Consecutive ticks on back-to-back cycles are all processed. No byte is dropped.
- Timeout expiring in the same cycle as a tick: the tick is processed against the current state and the timeout is ignored.
- Reset asserted mid-prefix: all state clears immediately. A `F0` sequence pending at reset is lost, and its following code is then treated as a make.

## Configuration
- `KB_EXT_ARROWS_EN` defined:
  - ext_make and ext_release of `E0 6B`, `E0 74`, `E0 75`, `E0 72` map to left, right, up and down (indices 0–3).
  - `E0 5A` (keypad enter) maps to enter (index 5).
  - These share held state with the base codes. For example, pressing `W` then up-arrow gives a single `key_press` pulse.
- `KB_EXT_ARROWS_EN` undefined: extended codes are decoded through the state machine but cause no key effect.

## Test plan
- Send `1D`, then `F0 1D` → `key_press[2]` pulses 1 cycle after the first tick. `key_held[2]` = 1, `dir` = 2, `dir_valid` = 1. After `1D` is released, all of these return to 0.
- Send `1C`, `1C`, `1C` (typematic) → exactly one `key_press[0]` pulse. `key_held` = `6'b000001` throughout.
- Hold `1B`, press `1C`, release `1C` → `dir` goes 3, then 0, then back to 3. Hold `1C` and `23`, release `23` after pressing it last → `dir` goes 1 → 0.
- Send `F0`, wait `TIMEOUT_CYCLES` + 2 idle cycles, send `2D` → treated as a make: `key_press[4]` pulses.
- Hold `5A` and `1D`, send `FF` → `key_held` = 0, `dir_valid` = 0, no pulses.
- Send `E0 75`, then `E0 F0 75` → with `KB_EXT_ARROWS_EN` defined: `key_press[2]` pulses, then held clears. Without the macro: outputs stay 0 and the state machine ends in IDLE.

Source files
------------

// File: rtl/kb_key_tracker.sv
// PS/2 scan-code decoder tracking six game keys with most-recent-wins direction arbitration.
// Optional macro KB_EXT_ARROWS_EN maps E0-prefixed arrow keys and keypad enter onto the base keys.
module kb_key_tracker #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    output logic [5:0] key_held,
    output logic [5:0] key_press,
    output logic [1:0] dir,
    output logic       dir_valid
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [5:0]    held_reg, held_next, press_next;
    logic [1:0]    last_reg, last_next, dir_next;
    logic          last_v_reg, last_v_next, dir_valid_next;
    logic          do_make, do_rel, is_ext, overrun;
    logic [3:0]    map;
    logic [5:0]    make_hit, rel_hit;

    // Returns {mapped, index[2:0]}.
    function automatic logic [3:0] map_base(input logic [7:0] c);
        case (c)
            8'h1C:   return 4'b1000;
            8'h23:   return 4'b1001;
            8'h1D:   return 4'b1010;
            8'h1B:   return 4'b1011;
            8'h2D:   return 4'b1100;
            8'h5A:   return 4'b1101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] map_ext(input logic [7:0] c);
`ifdef KB_EXT_ARROWS_EN
        case (c)
            8'h6B:   return 4'b1000;
            8'h74:   return 4'b1001;
            8'h75:   return 4'b1010;
            8'h72:   return 4'b1011;
            8'h5A:   return 4'b1101;
            default: return 4'b0000;
        endcase
`else
        return (c == 8'h00) ? 4'b0000 : 4'b0000;
`endif
    endfunction

    always_comb begin
        state_next = state_reg;
        do_make    = 1'b0;
        do_rel     = 1'b0;
        is_ext     = 1'b0;
        overrun    = 1'b0;
        if (scan_done_tick) begin
            if (scan_code == 8'h00 || scan_code == 8'hFF) begin
                overrun    = 1'b1;
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (scan_code == 8'hF0)      state_next = BREAK;
                        else if (scan_code == 8'hE0) state_next = EXT;
                        else                         do_make = 1'b1;
                    end
                    BREAK: begin
                        if (scan_code == 8'hE0)      state_next = EXT_BREAK;
                        else if (scan_code != 8'hF0) begin
                            do_rel     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    EXT: begin
                        if (scan_code == 8'hF0)      state_next = EXT_BREAK;
                        else if (scan_code != 8'hE0) begin
                            do_make    = 1'b1;
                            is_ext     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        if (scan_code != 8'hE0 && scan_code != 8'hF0) begin
                            do_rel     = 1'b1;
                            is_ext     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                endcase
            end
        end else if (state_reg != IDLE && cnt_reg == CW'(1)) begin
            // Abandon a prefix whose follow-up byte never arrived.
            state_next = IDLE;
        end
    end

    assign map = is_ext ? map_ext(scan_code) : map_base(scan_code);

    for (genvar gi = 0; gi < 6; gi++) begin : g_key
        assign make_hit[gi] = do_make && map[3] && (map[2:0] == 3'(gi));
        assign rel_hit[gi]  = do_rel  && map[3] && (map[2:0] == 3'(gi));
    end

    always_comb begin
        press_next  = make_hit & ~held_reg;
        held_next   = overrun ? 6'b0 : ((held_reg | make_hit) & ~rel_hit);
        last_next   = last_reg;
        last_v_next = last_v_reg;
        if (overrun) begin
            last_next   = 2'd0;
            last_v_next = 1'b0;
        end else if (|press_next[3:0]) begin
            last_next   = map[1:0];
            last_v_next = 1'b1;
        end
        dir_valid_next = |held_next[3:0];
        // A still-held most-recent key wins; otherwise fixed priority up > down > left > right.
        if (last_v_next && held_next[last_next]) dir_next = last_next;
        else if (held_next[2])                   dir_next = 2'd2;
        else if (held_next[3])                   dir_next = 2'd3;
        else if (held_next[0])                   dir_next = 2'd0;
        else if (held_next[1])                   dir_next = 2'd1;
        else                                     dir_next = 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            held_reg   <= '0;
            key_press  <= '0;
            last_reg   <= 2'd0;
            last_v_reg <= 1'b0;
            dir        <= 2'd0;
            dir_valid  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            held_reg   <= held_next;
            key_press  <= press_next;
            last_reg   <= last_next;
            last_v_reg <= last_v_next;
            dir        <= dir_next;
            dir_valid  <= dir_valid_next;
            if (scan_done_tick)       cnt_reg <= CW'(TIMEOUT_CYCLES);
            else if (cnt_reg != '0)   cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign key_held = held_reg;
endmodule

// File: tb/tb_kb_key_tracker.sv
// Table-driven bench for kb_key_tracker with a scoreboard queue of expected outputs.
module tb_kb_key_tracker;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [7:0] code;
    logic [5:0] key_held, key_press;
    logic [1:0] dir;
    logic       dir_valid;

    kb_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .scan_done_tick(tick), .scan_code(code),
        .key_held(key_held), .key_press(key_press), .dir(dir), .dir_valid(dir_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic [7:0] code;
        logic [5:0] held;
        logic [5:0] press;
        logic [1:0] dir;
        logic       dv;
    } vec_t;

    typedef struct {
        logic [5:0] held;
        logic [5:0] press;
        logic [1:0] dir;
        logic       dv;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic v(input logic tk, input logic [7:0] c, input logic [5:0] h,
                     input logic [5:0] p, input logic [1:0] d, input logic dv);
        vec_t r;
        r.tk = tk; r.code = c; r.held = h; r.press = p; r.dir = d; r.dv = dv;
        vt.push_back(r);
    endtask

    task automatic expect_out(input logic [5:0] h, input logic [5:0] p,
                              input logic [1:0] d, input logic dv);
        exp_t e;
        e.held = h; e.press = p; e.dir = d; e.dv = dv;
        sb.push_back(e);
    endtask

    task automatic compare(input string nm, input logic [7:0] c);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({key_held, key_press, dir, dir_valid} !== {e.held, e.press, e.dir, e.dv}) begin
            errors++;
            $display("FAIL %s code=%02h: got held=%b press=%b dir=%0d dv=%b, want held=%b press=%b dir=%0d dv=%b",
                     nm, c, key_held, key_press, dir, dir_valid, e.held, e.press, e.dir, e.dv);
        end else begin
            $display("ok   %s code=%02h tick=%b held=%b press=%b dir=%0d dv=%b",
                     nm, c, tick, key_held, key_press, dir, dir_valid);
        end
    endtask

    // One clock: drive at a negedge, sample at the next negedge.
    task automatic step(input string nm, input logic tk, input logic [7:0] c,
                        input logic [5:0] h, input logic [5:0] p,
                        input logic [1:0] d, input logic dv);
        tick = tk;
        code = c;
        expect_out(h, p, d, dv);
        @(negedge clk);
        compare(nm, c);
        tick = 1'b0;
    endtask

    initial begin
        // Press/release of up.
        v(1, 8'h1D, 6'b000100, 6'b000100, 2'd2, 1);
        v(0, 8'h00, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'hF0, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'h1D, 6'b000000, 6'b000000, 2'd0, 0);
        // Typematic repeat.
        v(1, 8'h1C, 6'b000001, 6'b000001, 2'd0, 1);
        v(1, 8'h1C, 6'b000001, 6'b000000, 2'd0, 1);
        v(1, 8'h1C, 6'b000001, 6'b000000, 2'd0, 1);
        v(1, 8'hF0, 6'b000001, 6'b000000, 2'd0, 1);
        v(1, 8'h1C, 6'b000000, 6'b000000, 2'd0, 0);
        // Hold down, press/release left.
        v(1, 8'h1B, 6'b001000, 6'b001000, 2'd3, 1);
        v(1, 8'h1C, 6'b001001, 6'b000001, 2'd0, 1);
        v(1, 8'hF0, 6'b001001, 6'b000000, 2'd0, 1);
        v(1, 8'h1C, 6'b001000, 6'b000000, 2'd3, 1);
        v(1, 8'hF0, 6'b001000, 6'b000000, 2'd3, 1);
        v(1, 8'h1B, 6'b000000, 6'b000000, 2'd0, 0);
        // Left then right, release right.
        v(1, 8'h1C, 6'b000001, 6'b000001, 2'd0, 1);
        v(1, 8'h23, 6'b000011, 6'b000010, 2'd1, 1);
        v(1, 8'hF0, 6'b000011, 6'b000000, 2'd1, 1);
        v(1, 8'h23, 6'b000001, 6'b000000, 2'd0, 1);
        v(1, 8'hF0, 6'b000001, 6'b000000, 2'd0, 1);
        v(1, 8'h1C, 6'b000000, 6'b000000, 2'd0, 0);
        // Right then down, release down: fallback to remaining held key.
        v(1, 8'h23, 6'b000010, 6'b000010, 2'd1, 1);
        v(1, 8'h1B, 6'b001010, 6'b001000, 2'd3, 1);
        v(1, 8'hF0, 6'b001010, 6'b000000, 2'd3, 1);
        v(1, 8'h1B, 6'b000010, 6'b000000, 2'd1, 1);
        v(1, 8'hF0, 6'b000010, 6'b000000, 2'd1, 1);
        v(1, 8'h23, 6'b000000, 6'b000000, 2'd0, 0);
        // Release of a key not held; unmapped make.
        v(1, 8'hF0, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'h2D, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'h15, 6'b000000, 6'b000000, 2'd0, 0);
        // Overrun clears everything.
        v(1, 8'h5A, 6'b100000, 6'b100000, 2'd0, 0);
        v(1, 8'h1D, 6'b100100, 6'b000100, 2'd2, 1);
        v(1, 8'hFF, 6'b000000, 6'b000000, 2'd0, 0);
        // 00 mid-prefix returns to IDLE: following 2D is a make.
        v(1, 8'hF0, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'h00, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'h2D, 6'b010000, 6'b010000, 2'd0, 0);
        v(1, 8'hF0, 6'b010000, 6'b000000, 2'd0, 0);
        v(1, 8'h2D, 6'b000000, 6'b000000, 2'd0, 0);
        // Extended up-arrow make/release, then a base make proves IDLE.
        v(1, 8'hE0, 6'b000000, 6'b000000, 2'd0, 0);
`ifdef KB_EXT_ARROWS_EN
        v(1, 8'h75, 6'b000100, 6'b000100, 2'd2, 1);
        v(1, 8'hE0, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'hF0, 6'b000100, 6'b000000, 2'd2, 1);
`else
        v(1, 8'h75, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'hE0, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'hF0, 6'b000000, 6'b000000, 2'd0, 0);
`endif
        v(1, 8'h75, 6'b000000, 6'b000000, 2'd0, 0);
        v(1, 8'h2D, 6'b010000, 6'b010000, 2'd0, 0);
        v(1, 8'hF0, 6'b010000, 6'b000000, 2'd0, 0);
        v(1, 8'h2D, 6'b000000, 6'b000000, 2'd0, 0);
`ifdef KB_EXT_ARROWS_EN
        // Base up then arrow up share one held bit: no second pulse.
        v(1, 8'h1D, 6'b000100, 6'b000100, 2'd2, 1);
        v(1, 8'hE0, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'h75, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'hF0, 6'b000100, 6'b000000, 2'd2, 1);
        v(1, 8'h1D, 6'b000000, 6'b000000, 2'd0, 0);
`endif

        reset = 1'b1;
        tick  = 1'b0;
        code  = 8'h00;
        repeat (2) @(negedge clk);
        expect_out(6'b0, 6'b0, 2'd0, 1'b0);
        compare("reset", code);
        reset = 1'b0;
        @(negedge clk);

        foreach (vt[i])
            step("vec", vt[i].tk, vt[i].code, vt[i].held, vt[i].press, vt[i].dir, vt[i].dv);

        // Prefix abandoned after the timeout: 2D becomes a make.
        step("to_f0", 1, 8'hF0, 6'b0, 6'b0, 2'd0, 0);
        repeat (TO + 2) step("to_idle", 0, 8'h00, 6'b0, 6'b0, 2'd0, 0);
        step("to_make", 1, 8'h2D, 6'b010000, 6'b010000, 2'd0, 0);
        step("to_f0b", 1, 8'hF0, 6'b010000, 6'b0, 2'd0, 0);
        step("to_rel", 1, 8'h2D, 6'b0, 6'b0, 2'd0, 0);

        // Tick in the cycle the timeout would fire: still a release.
        step("edge_f0", 1, 8'hF0, 6'b0, 6'b0, 2'd0, 0);
        repeat (TO - 1) step("edge_idle", 0, 8'h00, 6'b0, 6'b0, 2'd0, 0);
        step("edge_rel", 1, 8'h2D, 6'b0, 6'b0, 2'd0, 0);
        step("edge_make", 1, 8'h2D, 6'b010000, 6'b010000, 2'd0, 0);
        step("edge_f0b", 1, 8'hF0, 6'b010000, 6'b0, 2'd0, 0);
        step("edge_clr", 1, 8'h2D, 6'b0, 6'b0, 2'd0, 0);

        // Reset with a key held and F0 pending.
        step("rst_mk", 1, 8'h1D, 6'b000100, 6'b000100, 2'd2, 1);
        step("rst_f0", 1, 8'hF0, 6'b000100, 6'b0, 2'd2, 1);
        reset = 1'b1;
        #1;
        expect_out(6'b0, 6'b0, 2'd0, 1'b0);
        compare("rst_async", code);
        @(negedge clk);
        reset = 1'b0;
        step("rst_make", 1, 8'h1D, 6'b000100, 6'b000100, 2'd2, 1);
        step("rst_f0c", 1, 8'hF0, 6'b000100, 6'b0, 2'd2, 1);
        step("rst_rel", 1, 8'h1D, 6'b0, 6'b0, 2'd0, 0);
        step("rst_quiet", 0, 8'h00, 6'b0, 6'b0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
